// File: rtl/led_frame_feeder_pkg.sv
// led_frame_feeder_pkg: shared sizes, pixel field positions and FSM encoding for the LED frame feeder
package led_frame_feeder_pkg;
  localparam int NUM_LEDS  = 60;
  localparam int GROUP_LEN = 5;
  localparam int ADDR_W    = 6;
  localparam int PIX_W     = 24;
  localparam int R_LSB     = 16;
  localparam int G_LSB     = 8;
  localparam int B_LSB     = 0;
  typedef enum logic [1:0] {IDLE, PREFETCH, STREAM, DRAIN} state_t;
endpackage

// File: rtl/led_frame_feeder_pixel_bank_ram.sv
// pixel_bank_ram: simple dual-port RAM, one write and one registered read port
module pixel_bank_ram #(
  parameter int AW = 7,
  parameter int DW = 24
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/led_frame_feeder.sv
// led_frame_feeder: double-buffered pixel store streaming frames to a per-LED handshaking driver
module led_frame_feeder import led_frame_feeder_pkg::*; #(
  parameter int NUM_LEDS  = led_frame_feeder_pkg::NUM_LEDS,
  parameter int GROUP_LEN = led_frame_feeder_pkg::GROUP_LEN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  input  logic              commit,
  input  logic              finish_currentled,
  input  logic              finish_ledSet,
  output logic              data_ready,
  output logic [7:0]        red,
  output logic [7:0]        green,
  output logic [7:0]        blue,
  output logic [6:0]        start_index,
  output logic              busy,
  output logic              frame_done,
  output logic              front_bank,
  output logic              sync_err
);
  localparam int GW = GROUP_LEN > 1 ? $clog2(GROUP_LEN) : 1;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(NUM_LEDS - 1);
  localparam logic [GW-1:0]     GLAST = GW'(GROUP_LEN - 1);
  state_t state, state_nxt;
  logic prev_fc, ack, last, pending, swap, we, re;
  logic [1:0] pf_cnt;
  logic [ADDR_W-1:0] pix_idx, raddr;
  logic [GW-1:0] grp_cnt;
  logic [PIX_W-1:0] rdata;
  assign ack  = finish_currentled & ~prev_fc;
  assign last = pix_idx == LAST;
  assign busy = state != IDLE;
  assign we   = wr_en && ({1'b0, wr_addr} < (ADDR_W + 1)'(NUM_LEDS));
  assign re   = (state == PREFETCH && pf_cnt != 2'd2) || (state == STREAM && ack && !last);
  assign raddr = state == PREFETCH ? ADDR_W'(pf_cnt) : pix_idx + ADDR_W'(2);
  // a commit arriving in the DRAIN cycle still lands on this frame boundary
  assign swap = (pending && state == IDLE) || ((pending || commit) && state == DRAIN);
  always_comb begin
    state_nxt = state;
    state_nxt = state == IDLE     ? (run ? PREFETCH : IDLE) :
                state == PREFETCH ? (pf_cnt == 2'd2 ? STREAM : PREFETCH) :
                state == STREAM   ? (ack && last ? DRAIN : STREAM) :
                                    (run ? PREFETCH : IDLE);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nxt;
  // RAM output register doubles as the prefetch register holding pixel pix_idx+1
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      prev_fc     <= 1'b0;
      pf_cnt      <= 2'd0;
      pix_idx     <= '0;
      grp_cnt     <= '0;
      pending     <= 1'b0;
      front_bank  <= 1'b0;
      data_ready  <= 1'b0;
      frame_done  <= 1'b0;
      sync_err    <= 1'b0;
      red         <= 8'd0;
      green       <= 8'd0;
      blue        <= 8'd0;
      start_index <= 7'd0;
    end else begin
      prev_fc    <= finish_currentled;
      frame_done <= 1'b0;
      pending    <= (pending | commit) & ~swap;
      if (swap) front_bank <= ~front_bank;
      if (ack && (state == IDLE || state == PREFETCH || (finish_ledSet && grp_cnt != GLAST)))
        sync_err <= 1'b1;
      if (state == PREFETCH) begin
        pf_cnt <= pf_cnt + 2'd1;
        if (pf_cnt == 2'd1) {red, green, blue} <= {rdata[R_LSB +: 8], rdata[G_LSB +: 8], rdata[B_LSB +: 8]};
        if (pf_cnt == 2'd2) data_ready <= 1'b1;
      end
      if (state == STREAM && ack) begin
        if (last) begin
          data_ready <= 1'b0;
          frame_done <= 1'b1;
        end else begin
          {red, green, blue} <= {rdata[R_LSB +: 8], rdata[G_LSB +: 8], rdata[B_LSB +: 8]};
          pix_idx <= pix_idx + ADDR_W'(1);
          grp_cnt <= grp_cnt == GLAST ? '0 : grp_cnt + GW'(1);
          if (grp_cnt == GLAST) start_index <= start_index + 7'(GROUP_LEN);
        end
      end
      if (state == DRAIN) begin
        pf_cnt      <= 2'd0;
        pix_idx     <= '0;
        grp_cnt     <= '0;
        start_index <= 7'd0;
      end
    end
  pixel_bank_ram #(.AW(ADDR_W + 1), .DW(PIX_W)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr ({~front_bank, wr_addr}),
    .wdata (wr_data),
    .re    (re),
    .raddr ({front_bank, raddr}),
    .rdata (rdata)
  );
endmodule
